// File: rtl/divf_share_arbiter.sv
// divf_share_arbiter: round-robin wrapper that lets NUM_SHARED requesters
// share one pipelined divider. Operand pairs are joined and granted one per
// cycle, the grant index is remembered in an order FIFO, and each returning
// result is steered into the issuing requester's private output FIFO. A
// credit per output-FIFO slot guarantees results can always be accepted.
module divf_share_arbiter #(
    parameter int DATA_TYPE   = 32,
    parameter int NUM_SHARED  = 2,
    parameter int CREDITS     = 2,
    parameter int ORDER_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SHARED*DATA_TYPE-1:0] ins_lhs,
    input  logic [NUM_SHARED-1:0]           ins_lhs_valid,
    output logic [NUM_SHARED-1:0]           ins_lhs_ready,
    input  logic [NUM_SHARED*DATA_TYPE-1:0] ins_rhs,
    input  logic [NUM_SHARED-1:0]           ins_rhs_valid,
    output logic [NUM_SHARED-1:0]           ins_rhs_ready,
    output logic [DATA_TYPE-1:0]            op_lhs,
    output logic                            op_lhs_valid,
    input  logic                            op_lhs_ready,
    output logic [DATA_TYPE-1:0]            op_rhs,
    output logic                            op_rhs_valid,
    input  logic                            op_rhs_ready,
    input  logic [DATA_TYPE-1:0]            op_result,
    input  logic                            op_result_valid,
    output logic                            op_result_ready,
    output logic [NUM_SHARED*DATA_TYPE-1:0] outs,
    output logic [NUM_SHARED-1:0]           outs_valid,
    input  logic [NUM_SHARED-1:0]           outs_ready
);

    localparam int IW  = (NUM_SHARED > 1) ? $clog2(NUM_SHARED) : 1;
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int OPW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int QAW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int QCW = $clog2(ORDER_DEPTH + 1);

    // Arbitration state
    logic [IW-1:0]        ptr;
    logic [CW-1:0]        credit [NUM_SHARED];

    // Order FIFO: which requester each in-flight operation belongs to
    logic [IW-1:0]        order_mem [ORDER_DEPTH];
    logic [QAW-1:0]       order_rd;
    logic [QAW-1:0]       order_wr;
    logic [QCW-1:0]       order_cnt;

    // Per-requester output FIFOs
    logic [DATA_TYPE-1:0] out_mem [NUM_SHARED][CREDITS];
    logic [OPW-1:0]       out_rd  [NUM_SHARED];
    logic [OPW-1:0]       out_wr  [NUM_SHARED];
    logic [CW-1:0]        out_cnt [NUM_SHARED];

    logic [NUM_SHARED-1:0] elig;
    logic                  any_elig;
    logic [IW-1:0]         grant;
    logic                  order_full;
    logic                  order_empty;
    logic                  issue;
    logic                  ret;
    logic [IW-1:0]         ret_idx;
    logic [NUM_SHARED-1:0] out_push;
    logic [NUM_SHARED-1:0] out_pop;

    function automatic logic [QAW-1:0] order_next(input logic [QAW-1:0] p);
        return (p == QAW'(ORDER_DEPTH - 1)) ? '0 : p + QAW'(1);
    endfunction

    function automatic logic [OPW-1:0] out_next(input logic [OPW-1:0] p);
        return (p == OPW'(CREDITS - 1)) ? '0 : p + OPW'(1);
    endfunction

    // A requester may compete only with both operands present and a free result slot
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SHARED; i++) begin
            elig[i] = ins_lhs_valid[i] & ins_rhs_valid[i] & (credit[i] != '0);
        end
    end

    // Round-robin scan starting at ptr; descending loop lets the closest index win
    always_comb begin
        logic [IW:0] scan_sum;
        logic [IW-1:0] scan_idx;
        any_elig = 1'b0;
        grant    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NUM_SHARED - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr} + (IW + 1)'(k);
            if (scan_sum >= (IW + 1)'(NUM_SHARED)) begin
                scan_sum = scan_sum - (IW + 1)'(NUM_SHARED);
            end
            scan_idx = scan_sum[IW-1:0];
            if (elig[scan_idx]) begin
                any_elig = 1'b1;
                grant    = scan_idx;
            end
        end
    end

    assign order_full  = (order_cnt == QCW'(ORDER_DEPTH));
    assign order_empty = (order_cnt == '0);

    assign op_lhs_valid = !rst & any_elig & !order_full;
    assign op_rhs_valid = op_lhs_valid;
    assign op_lhs       = ins_lhs[int'(grant)*DATA_TYPE +: DATA_TYPE];
    assign op_rhs       = ins_rhs[int'(grant)*DATA_TYPE +: DATA_TYPE];

    assign issue = op_lhs_valid & op_lhs_ready & op_rhs_ready;

    assign op_result_ready = 1'b1;
    assign ret             = !rst & op_result_valid & !order_empty;
    assign ret_idx         = order_mem[order_rd];

    // Only the granted requester sees its operands consumed, and only on a real issue
    always_comb begin
        ins_lhs_ready = '0;
        ins_rhs_ready = '0;
        if (issue) begin
            ins_lhs_ready[grant] = 1'b1;
            ins_rhs_ready[grant] = 1'b1;
        end
    end

    // Output FIFO handshakes and head data for every requester
    always_comb begin
        outs       = '0;
        outs_valid = '0;
        out_push   = '0;
        out_pop    = '0;
        for (int i = 0; i < NUM_SHARED; i++) begin
            outs[i*DATA_TYPE +: DATA_TYPE] = out_mem[i][out_rd[i]];
            outs_valid[i] = !rst & (out_cnt[i] != '0);
            out_pop[i]    = outs_valid[i] & outs_ready[i];
            out_push[i]   = ret & (ret_idx == IW'(i));
        end
    end

    // Pointer advances past the winner; credits track free result slots per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < NUM_SHARED; i++) begin
                credit[i] <= CW'(CREDITS);
            end
        end else begin
            if (issue) begin
                ptr <= (grant == IW'(NUM_SHARED - 1)) ? '0 : grant + IW'(1);
            end
            for (int i = 0; i < NUM_SHARED; i++) begin
                if (issue && (grant == IW'(i)) && !out_pop[i]) begin
                    credit[i] <= credit[i] - CW'(1);
                end else if (out_pop[i] && !(issue && (grant == IW'(i)))) begin
                    credit[i] <= credit[i] + CW'(1);
                end
            end
        end
    end

    // Order FIFO storage; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (issue) begin
            order_mem[order_wr] <= grant;
        end
    end

    // Order FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            order_rd  <= '0;
            order_wr  <= '0;
            order_cnt <= '0;
        end else begin
            if (issue) begin
                order_wr <= order_next(order_wr);
            end
            if (ret) begin
                order_rd <= order_next(order_rd);
            end
            if (issue && !ret) begin
                order_cnt <= order_cnt + QCW'(1);
            end else if (ret && !issue) begin
                order_cnt <= order_cnt - QCW'(1);
            end
        end
    end

    // Output FIFO storage; a returning result lands in its issuer's FIFO
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SHARED; i++) begin
            if (out_push[i]) begin
                out_mem[i][out_wr[i]] <= op_result;
            end
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SHARED; i++) begin
                out_rd[i]  <= '0;
                out_wr[i]  <= '0;
                out_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SHARED; i++) begin
                if (out_push[i]) begin
                    out_wr[i] <= out_next(out_wr[i]);
                end
                if (out_pop[i]) begin
                    out_rd[i] <= out_next(out_rd[i]);
                end
                if (out_push[i] && !out_pop[i]) begin
                    out_cnt[i] <= out_cnt[i] + CW'(1);
                end else if (out_pop[i] && !out_push[i]) begin
                    out_cnt[i] <= out_cnt[i] - CW'(1);
                end
            end
        end
    end

    // A result with nothing outstanding means the shared unit broke protocol
    assert property (@(posedge clk) disable iff (rst) op_result_valid |-> !order_empty);

endmodule

// File: doc/divf_share_arbiter.md
# divf_share_arbiter

Round-robin sharing wrapper that time-multiplexes one pipelined floating-point divider (`divf`-style unit with lhs/rhs/result valid/ready channels) among `NUM_SHARED` dataflow requesters. It joins each requester's operand pair, grants one requester per cycle, and records the grant index in an order FIFO. It routes each returning result to the issuing requester's private output FIFO. Per-requester credit counters ensure a result never blocks the shared unit (no head-of-line deadlock). The block sits between the elastic circuit's operand producers and the single shared divider instance.

## Interface
- `DATA_TYPE`, 32: operand/result width.
- `NUM_SHARED`, 2: number of requesters (≥2).
- `CREDITS`, 2: output FIFO depth and initial credit per requester (≥1).
- `ORDER_DEPTH`, 16: order FIFO depth; must be ≥ shared-unit max in-flight count.

Ports (index width `IW = max(1, clog2(NUM_SHARED))`; requester i occupies bits `[i*DATA_TYPE +: DATA_TYPE]`):
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `ins_lhs  in  NUM_SHARED*DATA_TYPE`: per-requester lhs data.
- `ins_lhs_valid  in  NUM_SHARED`: lhs valid per requester.
- `ins_lhs_ready  out  NUM_SHARED`: lhs ready per requester.
- `ins_rhs  in  NUM_SHARED*DATA_TYPE`: per-requester rhs data.
- `ins_rhs_valid  in  NUM_SHARED`: rhs valid per requester.
- `ins_rhs_ready  out  NUM_SHARED`: rhs ready per requester.
- `op_lhs  out  DATA_TYPE`: lhs to shared unit.
- `op_lhs_valid  out  1`: lhs valid to shared unit.
- `op_lhs_ready  in  1`: lhs ready from shared unit.
- `op_rhs  out  DATA_TYPE`: rhs to shared unit.
- `op_rhs_valid  out  1`: rhs valid to shared unit.
- `op_rhs_ready  in  1`: rhs ready from shared unit.
- `op_result  in  DATA_TYPE`: result from shared unit.
- `op_result_valid  in  1`: result valid from shared unit.
- `op_result_ready  out  1`: result ready to shared unit; constant 1.
- `outs  out  NUM_SHARED*DATA_TYPE`: per-requester result data.
- `outs_valid  out  NUM_SHARED`: result valid per requester.
- `outs_ready  in  NUM_SHARED`: result ready per requester.

## Operation
- Eligibility: `elig[i] = ins_lhs_valid[i] & ins_rhs_valid[i] & (credit[i] != 0)`.
- Grant: first eligible index scanning `ptr, ptr+1, …` modulo `NUM_SHARED`. The grant depends only on `elig`, `ptr` and order-FIFO full, never on `op_*_ready`.
- `op_lhs_valid = op_rhs_valid = any_elig & !order_full`. `op_lhs` and `op_rhs` mux the granted requester's data.
- Issue: `op_lhs_valid & op_lhs_ready & op_rhs_ready`. On issue:
  - assert `ins_lhs_ready[g]` and `ins_rhs_ready[g]` (only the granted index; all other readies 0);
  - push `g` into the order FIFO;
  - decrement `credit[g]`;
  - set `ptr = (g+1) mod NUM_SHARED`.
- No issue: `ptr` holds.
- Return: when `op_result_valid` is high, pop the order-FIFO head `h` and push `op_result` into `outfifo[h]`. Credits guarantee space, so `op_result_ready` is tied to 1.
- Output: `outs_valid[i] = !outfifo[i].empty`. A pop on `outs_valid[i] & outs_ready[i]` increments `credit[i]`.
- Credit update: issue and pop for the same i in the same cycle leave `credit[i]` unchanged.
- Invariant: `credit[i] + inflight[i] + occupancy(outfifo[i]) == CREDITS`.
- Order FIFO full: issue blocked, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full are both performed.
- Output FIFO: push and pop of the same FIFO in the same cycle are both performed. Full-plus-push cannot occur (credit invariant).
- `op_result_valid` with the order FIFO empty is a protocol error: simulation assertion fires, result is dropped, state is unchanged.
- Single-requester pressure: a requester with zero credit is skipped, and others proceed.

## Timing
- Reset (rst=1 at posedge) state: `ptr=0`, all `credit=CREDITS`, all FIFOs empty.
- Outputs while rst is high or after reset: `outs_valid=0`, `op_*_valid=0`, `ins_*_ready=0`, `op_result_ready=1`.
- Reset mid-operation discards in-flight bookkeeping. The shared unit must be reset in the same cycle.
- Operand path: combinational, 0 cycles from requester valid to `op_*_valid`.
- Result path: registered; `op_result_valid` at cycle t gives `outs_valid[h]` at t+1.
- Throughput: one issue per cycle, and one return per cycle, sustained.
- Fairness: a continuously eligible requester is granted within `NUM_SHARED` issue cycles.

## Test plan
- Reset: hold rst 3 cycles with all inputs valid -> all readies 0, `outs_valid=0`. Then the first issue grants requester 0 and `ptr` becomes 1.
- Round-robin: NUM_SHARED=2, both requesters permanently valid, `op_*_ready=1`, fixed 9-cycle model unit -> grants alternate 0,1,0,1; results appear on requesters 0,1,0,1 in issue order with correct quotients (6.0/2.0=3.0 on 0, 1.0/4.0=0.25 on 1).
- Credit stall: `outs_ready[0]=0`, CREDITS=2 -> requester 0 issues exactly 2 ops and requester 1 gets every grant afterwards. Raising `outs_ready[0]` restores 0's eligibility one cycle after the pop.
- Order full: ORDER_DEPTH=4, model unit with 20-cycle latency -> exactly 4 issues, then `op_lhs_valid=0` until the first result returns.
- Back-pressure: `op_rhs_ready=0` for 5 cycles -> no `ins_*_ready`, `ptr` and credits frozen, `op_lhs_valid` stays 1 with stable `op_lhs`.
- Simultaneous issue and pop on the same requester with credit=1 -> credit stays 1. An issue during the same cycle as a result return for full order FIFO minus one -> both complete, and FIFO occupancy is unchanged.
